spike_window_decoder: RTL and testbench

SPIKE_WINDOW_DECODER -- requirements
Module: spike_window_decoder

---
 rtl/spike_window_decoder.sv | 155 +++++++++++++++
 tb/tb_spike_window_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_window_decoder.sv
// Spike-count window decoder: accumulates per-channel spikes over a window, then scans for the winning class.
// Optional SPIKE_DEC_SEG7_EN adds a registered seven-segment decode of class_out on seg_out.
module spike_window_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] spikes_in,
  input  logic       step,
  input  logic [7:0] win_len,
  output logic [2:0] class_out,
  output logic [7:0] class_cnt,
  output logic       result_valid,
  output logic       overrun,
  output logic [6:0] seg_out
);

  localparam int unsigned N_CH   = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned STEP_W = 9;
  localparam int unsigned IDX_W  = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [CNT_W-1:0]  r_live [N_CH];
  logic [CNT_W-1:0]  r_snap [N_CH];
  logic [CNT_W-1:0]  w_live_inc [N_CH];
  logic [STEP_W-1:0] r_step_cnt;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  w_len_sel;
  logic [STEP_W-1:0] w_len_eff;
  logic              w_accept;
  logic              w_close;
  logic              w_start_scan;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_best_idx;
  logic [CNT_W-1:0]  r_best_cnt;

  // At window start the live win_len applies directly; afterwards the latched copy does.
  always_comb begin
    w_accept     = step & ena;
    w_len_sel    = (r_step_cnt == STEP_W'(0)) ? win_len : r_len;
    w_len_eff    = (w_len_sel == CNT_W'(0)) ? STEP_W'(256) : {1'b0, w_len_sel};
    w_close      = w_accept && ((r_step_cnt + STEP_W'(1)) == w_len_eff);
    w_start_scan = w_close && (r_state == S_IDLE);
    for (int i = 0; i < N_CH; i++) begin
      if (w_accept && spikes_in[i] && (r_live[i] != {CNT_W{1'b1}}))
        w_live_inc[i] = r_live[i] + CNT_W'(1);
      else
        w_live_inc[i] = r_live[i];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_close) w_state_next = S_SCAN;
      S_SCAN:   if (r_idx == IDX_W'(N_CH - 1)) w_state_next = S_REPORT;
      S_REPORT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Live accumulation, window close and snapshot capture; a close during a scan is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt <= '0;
      r_len      <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_live[i] <= '0;
        r_snap[i] <= '0;
      end
    end else begin
      if (r_step_cnt == STEP_W'(0)) r_len <= win_len;
      if (w_close) begin
        r_step_cnt <= '0;
        for (int i = 0; i < N_CH; i++) r_live[i] <= '0;
        if (w_start_scan) begin
          for (int i = 0; i < N_CH; i++) r_snap[i] <= w_live_inc[i];
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        if (w_accept) r_step_cnt <= r_step_cnt + STEP_W'(1);
        for (int i = 0; i < N_CH; i++) r_live[i] <= w_live_inc[i];
      end
    end
  end

  // One channel per cycle; strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (w_start_scan) begin
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (r_state == S_SCAN) begin
      if (r_snap[r_idx] > r_best_cnt) begin
        r_best_cnt <= r_snap[r_idx];
        r_best_idx <= r_idx;
      end
      r_idx <= r_idx + IDX_W'(1);
    end
  end

`ifdef SPIKE_DEC_SEG7_EN
  function automatic logic [6:0] f_seg(input logic [2:0] d);
    case (d)
      3'd0:    f_seg = 7'h3F;
      3'd1:    f_seg = 7'h06;
      3'd2:    f_seg = 7'h5B;
      3'd3:    f_seg = 7'h4F;
      3'd4:    f_seg = 7'h66;
      3'd5:    f_seg = 7'h6D;
      3'd6:    f_seg = 7'h7D;
      default: f_seg = 7'h07;
    endcase
  endfunction
`else
  assign seg_out = 7'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      class_out    <= '0;
      class_cnt    <= '0;
      result_valid <= 1'b0;
`ifdef SPIKE_DEC_SEG7_EN
      seg_out      <= 7'h3F;
`endif
    end else begin
      result_valid <= (r_state == S_REPORT);
      if (r_state == S_REPORT) begin
        class_out <= r_best_idx;
        class_cnt <= r_best_cnt;
`ifdef SPIKE_DEC_SEG7_EN
        seg_out   <= f_seg(r_best_idx);
`endif
      end
    end
  end

endmodule

// File: tb/tb_spike_window_decoder.sv
// Bench for spike_window_decoder: directed scenarios plus random traffic against a window-level model.
module tb_spike_window_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] spikes_in;
  logic       step;
  logic [7:0] win_len;
  logic [2:0] class_out;
  logic [7:0] class_cnt;
  logic       result_valid;
  logic       overrun;
  logic [6:0] seg_out;

  spike_window_decoder dut (
    .clk(clk), .rst(rst), .ena(ena), .spikes_in(spikes_in), .step(step),
    .win_len(win_len), .class_out(class_out), .class_cnt(class_cnt),
    .result_valid(result_valid), .overrun(overrun), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Model state: window counts, steps taken, length in force, pending report.
  int m_cnt [8];
  int m_steps = 0;
  int m_latched = 0;
  int m_scan_start = 0;
  bit m_have_scan = 0;
  int m_due = -1;
  int m_pend_cls = 0;
  int m_pend_cnt = 0;
  int exp_cls = 0;
  int exp_cnt = 0;
  bit exp_valid = 0;
  bit exp_ovr = 0;

  function automatic int seg_of(input int c);
    case (c)
      0: return 'h3F; 1: return 'h06; 2: return 'h5B; 3: return 'h4F;
      4: return 'h66; 5: return 'h6D; 6: return 'h7D; default: return 'h07;
    endcase
  endfunction

  function automatic int exp_seg();
`ifdef SPIKE_DEC_SEG7_EN
    return seg_of(exp_cls);
`else
    return 0;
`endif
  endfunction

  task automatic cmp(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // A report is due 9 edges after an accepted close; the decoder is busy for closes 1..9 edges later.
  task automatic model_edge();
    int len;
    int best;
    int win;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_steps = 0; m_latched = 0; m_have_scan = 0; m_due = -1;
      exp_cls = 0; exp_cnt = 0; exp_valid = 0; exp_ovr = 0;
      chk_en = 1;
      return;
    end
    exp_valid = 0;
    if (m_due == cyc) begin
      exp_valid = 1; exp_cls = m_pend_cls; exp_cnt = m_pend_cnt; m_due = -1;
    end
    if (m_steps == 0) m_latched = int'(win_len);
    if (ena && step) begin
      len = (m_latched == 0) ? 256 : m_latched;
      for (int i = 0; i < 8; i++)
        if (spikes_in[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
      m_steps = m_steps + 1;
      if (m_steps == len) begin
        if (m_have_scan && (cyc - m_scan_start) >= 1 && (cyc - m_scan_start) <= 9) begin
          exp_ovr = 1;
        end else begin
          best = 0; win = 0;
          for (int i = 0; i < 8; i++)
            if (m_cnt[i] > best) begin best = m_cnt[i]; win = i; end
          m_pend_cls = win; m_pend_cnt = best;
          m_due = cyc + 9; m_scan_start = cyc; m_have_scan = 1;
        end
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_steps = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model_edge();
    #1;
    if (chk_en) begin
      cmp("result_valid", int'(result_valid), int'(exp_valid));
      cmp("class_out", int'(class_out), exp_cls);
      cmp("class_cnt", int'(class_cnt), exp_cnt);
      cmp("overrun", int'(overrun), int'(exp_ovr));
      cmp("seg_out", int'(seg_out), exp_seg());
    end
  end

  task automatic do_step(input logic [7:0] s, output int edge_no);
    @(negedge clk);
    ena = 1'b1; step = 1'b1; spikes_in = s; edge_no = cyc + 1;
    @(negedge clk);
    step = 1'b0; spikes_in = 8'h00;
  endtask

  task automatic wait_valid(input int close_edge, input string name, input int want_cls, input int want_cnt);
    bit seen;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (result_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    cmp({name, " pulse seen"}, int'(seen), 1);
    if (seen) begin
      cmp({name, " latency"}, cyc - close_edge, 9);
      cmp({name, " class_out"}, int'(class_out), want_cls);
      cmp({name, " class_cnt"}, int'(class_cnt), want_cnt);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    cmp({name, " class_out"}, int'(class_out), 0);
    cmp({name, " class_cnt"}, int'(class_cnt), 0);
    cmp({name, " result_valid"}, int'(result_valid), 0);
    cmp({name, " overrun"}, int'(overrun), 0);
`ifdef SPIKE_DEC_SEG7_EN
    cmp({name, " seg_out"}, int'(seg_out), 'h3F);
`else
    cmp({name, " seg_out"}, int'(seg_out), 0);
`endif
  endtask

  initial begin
    int e;
    int e1;
    int nv;
    rst = 1'b1; ena = 1'b0; step = 1'b0; spikes_in = 8'h00; win_len = 8'd4;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    win_len = 8'd4;
    repeat (4) do_step(8'h08, e);
    wait_valid(e, "basic", 3, 4);

    win_len = 8'd2;
    repeat (2) do_step(8'h81, e);
    wait_valid(e, "tie", 0, 2);
    repeat (2) do_step(8'h00, e);
    wait_valid(e, "zero", 0, 0);

    win_len = 8'd1;
    do_step(8'h04, e);
    wait_valid(e, "class2", 2, 1);
`ifdef SPIKE_DEC_SEG7_EN
    cmp("class2 seg_out", int'(seg_out), 'h5B);
`else
    cmp("class2 seg_out", int'(seg_out), 0);
`endif

    // 256-step window with continuous strobes; no report may appear early.
    win_len = 8'd0;
    nv = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (result_valid) nv++;
      ena = 1'b1; step = 1'b1; spikes_in = 8'h40; e = cyc + 1;
    end
    @(negedge clk);
    if (result_valid) nv++;
    step = 1'b0; spikes_in = 8'h00;
    cmp("sat early pulses", nv, 0);
    wait_valid(e, "sat", 6, 255);

    // Back-to-back closes: the second lands mid-scan.
    win_len = 8'd1;
    @(negedge clk);
    ena = 1'b1; step = 1'b1; spikes_in = 8'h02; e1 = cyc + 1;
    @(negedge clk);
    spikes_in = 8'h10;
    @(negedge clk);
    step = 1'b0; spikes_in = 8'h00;
    cmp("overrun set", int'(overrun), 1);
    wait_valid(e1, "ovr first", 1, 1);

    // Abort a scan with reset.
    win_len = 8'd2;
    repeat (2) do_step(8'h04, e);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (result_valid) nv++;
    end
    cmp("abort pulses", nv, 0);
    win_len = 8'd3;
    repeat (3) do_step(8'h20, e);
    wait_valid(e, "after abort", 5, 3);

    // Random traffic, including mid-window length changes and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      ena = ($urandom_range(0, 7) != 0);
      step = ($urandom_range(0, 2) != 0);
      spikes_in = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      win_len = ($urandom_range(0, 31) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(1, 6));
    end
    @(negedge clk);
    rst = 1'b0; step = 1'b0; ena = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
